// File: rtl/rps_pkg.sv
// Shared encodings, FSM states and move-comparison helper for the rock-paper-scissors round judge.
package rps_pkg;

  localparam logic [1:0] ROCK     = 2'd0;
  localparam logic [1:0] PAPER    = 2'd1;
  localparam logic [1:0] SCISSORS = 2'd2;
  localparam logic [1:0] MOVE_INV = 2'd3;

  localparam logic [1:0] OUT_TIE    = 2'd0;
  localparam logic [1:0] OUT_AI     = 2'd1;
  localparam logic [1:0] OUT_PLAYER = 2'd2;

  localparam logic [7:0] REWARD_WIN  = 8'h01;
  localparam logic [7:0] REWARD_LOSS = 8'hFF;
  localparam logic [7:0] REWARD_TIE  = 8'h00;

  typedef enum logic [1:0] {StIdle, StReq, StJudge, StDone} state_e;

  // True when move a defeats move b.
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    logic r;
    r = 1'b0;
    unique case (b)
      ROCK:     r = (a == PAPER);
      PAPER:    r = (a == SCISSORS);
      SCISSORS: r = (a == ROCK);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: 2-flop synchroniser, stable-high counter and rising-edge strobe.
// Compiled only when RPS_DEBOUNCE_EN is defined.
`ifdef RPS_DEBOUNCE_EN
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic strobe
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            strobe_q, strobe_d;

  // Counter saturates at CntMax; the strobe fires only on the step that reaches it.
  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (!sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d    = cnt_q + CntW'(1);
      strobe_d = (cnt_d == CntMax);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key};
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule
`endif

// File: rtl/rps_round_judge.sv
// Round judge: takes the player's move, requests the AI move, scores the round and keeps tallies.
// RPS_DEBOUNCE_EN routes move_valid through key_debounce instead of a plain synchroniser.
module rps_round_judge
  import rps_pkg::*;
#(
  parameter int unsigned ROUNDS = 60
`ifdef RPS_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_valid,
  input  logic [1:0] player_move,
  output logic       ai_req,
  input  logic       ai_valid,
  input  logic [1:0] ai_choice,
  output logic       result_valid,
  output logic [3:0] combination,
  output logic [7:0] reward,
  output logic [1:0] outcome,
  output logic [5:0] wins,
  output logic [5:0] losses,
  output logic [5:0] ties,
  output logic [5:0] round_cnt,
  output logic       game_over,
  output logic       ai_err
);

  localparam logic [5:0] RoundsLast = 6'(ROUNDS);

  logic move_strobe;

`ifdef RPS_DEBOUNCE_EN
  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clock (clock),
    .reset (reset),
    .key   (move_valid),
    .strobe(move_strobe)
  );
`else
  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], move_valid};
      prev_q <= sync_q[1];
    end
  end

  assign move_strobe = sync_q[1] & ~prev_q;
`endif

  state_e     state_q, state_d;
  logic [1:0] player_q, player_d;
  logic [1:0] ai_q, ai_d;
  logic       ai_req_q, ai_req_d;
  logic       result_valid_q, result_valid_d;
  logic [3:0] combination_q, combination_d;
  logic [7:0] reward_q, reward_d;
  logic [1:0] outcome_q, outcome_d;
  logic [5:0] wins_q, wins_d;
  logic [5:0] losses_q, losses_d;
  logic [5:0] ties_q, ties_d;
  logic [5:0] round_cnt_q, round_cnt_d;
  logic       game_over_q, game_over_d;
  logic       ai_err_q, ai_err_d;

  always_comb begin
    state_d        = state_q;
    player_d       = player_q;
    ai_d           = ai_q;
    ai_req_d       = 1'b0;
    result_valid_d = 1'b0;
    combination_d  = combination_q;
    reward_d       = reward_q;
    outcome_d      = outcome_q;
    wins_d         = wins_q;
    losses_d       = losses_q;
    ties_d         = ties_q;
    round_cnt_d    = round_cnt_q;
    game_over_d    = game_over_q;
    ai_err_d       = ai_err_q;

    unique case (state_q)
      StIdle: begin
        if (move_strobe && (player_move != MOVE_INV) && !game_over_q) begin
          player_d = player_move;
          ai_req_d = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (ai_valid) begin
          // An invalid AI move is scored as rock and flagged.
          if (ai_choice == MOVE_INV) begin
            ai_d     = ROCK;
            ai_err_d = 1'b1;
          end else begin
            ai_d = ai_choice;
          end
          state_d = StJudge;
        end
      end
      StJudge: begin
        combination_d  = {ai_q, player_q};
        result_valid_d = 1'b1;
        round_cnt_d    = round_cnt_q + 6'd1;
        if (ai_q == player_q) begin
          outcome_d = OUT_TIE;
          reward_d  = REWARD_TIE;
          ties_d    = ties_q + 6'd1;
        end else if (beats(ai_q, player_q)) begin
          outcome_d = OUT_AI;
          reward_d  = REWARD_WIN;
          wins_d    = wins_q + 6'd1;
        end else begin
          outcome_d = OUT_PLAYER;
          reward_d  = REWARD_LOSS;
          losses_d  = losses_q + 6'd1;
        end
        if (round_cnt_d == RoundsLast) begin
          game_over_d = 1'b1;
          state_d     = StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StDone: begin
        game_over_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= StIdle;
      player_q       <= '0;
      ai_q           <= '0;
      ai_req_q       <= 1'b0;
      result_valid_q <= 1'b0;
      combination_q  <= '0;
      reward_q       <= '0;
      outcome_q      <= '0;
      wins_q         <= '0;
      losses_q       <= '0;
      ties_q         <= '0;
      round_cnt_q    <= '0;
      game_over_q    <= 1'b0;
      ai_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      player_q       <= player_d;
      ai_q           <= ai_d;
      ai_req_q       <= ai_req_d;
      result_valid_q <= result_valid_d;
      combination_q  <= combination_d;
      reward_q       <= reward_d;
      outcome_q      <= outcome_d;
      wins_q         <= wins_d;
      losses_q       <= losses_d;
      ties_q         <= ties_d;
      round_cnt_q    <= round_cnt_d;
      game_over_q    <= game_over_d;
      ai_err_q       <= ai_err_d;
    end
  end

  assign ai_req       = ai_req_q;
  assign result_valid = result_valid_q;
  assign combination  = combination_q;
  assign reward       = reward_q;
  assign outcome      = outcome_q;
  assign wins         = wins_q;
  assign losses       = losses_q;
  assign ties         = ties_q;
  assign round_cnt    = round_cnt_q;
  assign game_over    = game_over_q;
  assign ai_err       = ai_err_q;

endmodule

// File: tb/tb_rps_round_judge.sv
// Scoreboard bench for rps_round_judge (ROUNDS=4, default synchroniser build).
module tb_rps_round_judge;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] player_move = 2'd0;
  logic       ai_valid = 1'b0;
  logic [1:0] ai_choice = 2'd0;
  logic       ai_req, result_valid, game_over, ai_err;
  logic [3:0] combination;
  logic [7:0] reward;
  logic [1:0] outcome;
  logic [5:0] wins, losses, ties, round_cnt;

  rps_round_judge #(
    .ROUNDS(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .move_valid  (move_valid),
    .player_move (player_move),
    .ai_req      (ai_req),
    .ai_valid    (ai_valid),
    .ai_choice   (ai_choice),
    .result_valid(result_valid),
    .combination (combination),
    .reward      (reward),
    .outcome     (outcome),
    .wins        (wins),
    .losses      (losses),
    .ties        (ties),
    .round_cnt   (round_cnt),
    .game_over   (game_over),
    .ai_err      (ai_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] comb;
    logic [7:0] rew;
    logic [1:0] outc;
    logic [5:0] w;
    logic [5:0] l;
    logic [5:0] t;
    logic [5:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   mw = 0, ml = 0, mt = 0, mr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every result pulse is matched against the oldest expected round.
  always @(negedge clock) begin
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected result_valid: got 1, expected 0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("combination", 32'(combination), 32'(e.comb));
        check("reward", 32'(reward), 32'(e.rew));
        check("outcome", 32'(outcome), 32'(e.outc));
        check("wins", 32'(wins), 32'(e.w));
        check("losses", 32'(losses), 32'(e.l));
        check("ties", 32'(ties), 32'(e.t));
        check("round_cnt", 32'(round_cnt), 32'(e.r));
      end
    end
  end

  task automatic push_expected(input logic [3:0] comb, input logic [7:0] rew,
                               input logic [1:0] outc);
    exp_t e;
    if (outc == 2'd1) mw++;
    else if (outc == 2'd2) ml++;
    else mt++;
    mr++;
    e.comb = comb; e.rew = rew; e.outc = outc;
    e.w = 6'(mw); e.l = 6'(ml); e.t = 6'(mt); e.r = 6'(mr);
    exp_q.push_back(e);
  endtask

  task automatic wait_req(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      seen = ai_req;
    end
  endtask

  task automatic play(input logic [1:0] pm, input logic [1:0] ac, input logic [3:0] comb,
                      input logic [7:0] rew, input logic [1:0] outc);
    logic seen;
    @(negedge clock);
    player_move = pm;
    move_valid  = 1'b1;
    @(negedge clock);
    move_valid = 1'b0;
    wait_req(seen);
    check("ai_req after strobe", 32'(seen), 32'd1);
    if (seen) begin
      push_expected(comb, rew, outc);
      ai_choice = ac;
      ai_valid  = 1'b1;
      @(negedge clock);
      check("ai_req single pulse", 32'(ai_req), 32'd0);
      ai_valid = 1'b0;
      @(negedge clock);
      check("result latency", 32'(result_valid), 32'd1);
      @(negedge clock);
      check("result single pulse", 32'(result_valid), 32'd0);
    end
  endtask

  task automatic strobe_expect_no_req(input logic [1:0] pm);
    logic seen;
    @(negedge clock);
    player_move = pm;
    move_valid  = 1'b1;
    @(negedge clock);
    move_valid = 1'b0;
    wait_req(seen);
    check("no ai_req for ignored strobe", 32'(seen), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    mw = 0; ml = 0; mt = 0; mr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   rv_seen;

    // Reset held for 3 cycles: everything idle and zero.
    repeat (3) @(negedge clock);
    check("reset ai_req", 32'(ai_req), 32'd0);
    check("reset result_valid", 32'(result_valid), 32'd0);
    check("reset result fields", 32'({combination, reward, outcome}), 32'd0);
    check("reset counters", 32'({wins, losses, ties, round_cnt}), 32'd0);
    check("reset flags", 32'({game_over, ai_err}), 32'd0);
    reset = 1'b1;

    play(2'd0, 2'd1, 4'b0100, 8'h01, 2'd1);
    check("wins after AI win", 32'(wins), 32'd1);

    strobe_expect_no_req(2'd3);
    check("round_cnt after invalid move", 32'(round_cnt), 32'd1);
    check("combination held", 32'(combination), 32'h4);

    play(2'd0, 2'd2, 4'b1000, 8'hFF, 2'd2);
    check("losses after AI loss", 32'(losses), 32'd1);
    play(2'd2, 2'd2, 4'b1010, 8'h00, 2'd0);
    check("ties after tie", 32'(ties), 32'd1);
    check("game_over before last round", 32'(game_over), 32'd0);
    check("ai_err before invalid AI", 32'(ai_err), 32'd0);

    // Invalid AI move is judged as rock: paper beats it.
    play(2'd1, 2'd3, 4'b0001, 8'hFF, 2'd2);
    check("ai_err set", 32'(ai_err), 32'd1);
    check("game_over after ROUNDS", 32'(game_over), 32'd1);
    check("round_cnt at ROUNDS", 32'(round_cnt), 32'd4);

    strobe_expect_no_req(2'd0);
    check("ai_err sticky", 32'(ai_err), 32'd1);

    do_reset();
    check("game_over cleared", 32'(game_over), 32'd0);
    check("ai_err cleared", 32'(ai_err), 32'd0);
    check("round_cnt cleared", 32'(round_cnt), 32'd0);

    // Reset while awaiting the AI move aborts the round.
    @(negedge clock);
    player_move = 2'd1;
    move_valid  = 1'b1;
    @(negedge clock);
    move_valid = 1'b0;
    wait_req(seen);
    check("ai_req before abort", 32'(seen), 32'd1);
    reset     = 1'b0;
    ai_choice = 2'd1;
    ai_valid  = 1'b1;
    rv_seen   = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (result_valid) rv_seen++;
    end
    ai_valid = 1'b0;
    check("no result after abort", 32'(rv_seen), 32'd0);
    check("counters after abort", 32'({wins, losses, ties, round_cnt}), 32'd0);

    // Level held high yields exactly one request.
    @(negedge clock);
    player_move = 2'd1;
    move_valid  = 1'b1;
    wait_req(seen);
    check("ai_req with held level", 32'(seen), 32'd1);
    if (seen) begin
      push_expected(4'b1001, 8'h01, 2'd1);
      ai_choice = 2'd2;
      ai_valid  = 1'b1;
      @(negedge clock);
      ai_valid = 1'b0;
      @(negedge clock);
      check("held-level result latency", 32'(result_valid), 32'd1);
    end
    wait_req(seen);
    check("no repeat request while held", 32'(seen), 32'd0);
    move_valid = 1'b0;

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
